// File: rtl/bri_drive_seq_if.sv
// Bundle of the bridge sequencer's timer-side and gate-side signals.
// The slave modport is the sequencer; the master modport is whatever drives it.
interface bri_drive_seq_if #(
  parameter int DEAD_W = 4
);
  logic              clk_4f_en;
  logic              state_start;
  logic [7:0]        count;
  logic [7:0]        half_num;
  logic [DEAD_W-1:0] dead_cyc;
  logic              bri_a;
  logic              bri_b;
  logic              timer_stop;
  logic              pulse_done;
  logic              pulse_abort;
  logic              busy;
  logic              phase_tick;

  modport master (
    output clk_4f_en, state_start, count, half_num, dead_cyc,
    input  bri_a, bri_b, timer_stop, pulse_done, pulse_abort, busy, phase_tick
  );

  modport slave (
    input  clk_4f_en, state_start, count, half_num, dead_cyc,
    output bri_a, bri_b, timer_stop, pulse_done, pulse_abort, busy, phase_tick
  );
endinterface

// File: rtl/bri_drive_seq.sv
// H-bridge transmit-pulse sequencer: turns the timer's quarter-period count into
// dead-time-protected diagonal-leg gate drives and freezes the timer at pulse end.
module bri_drive_seq #(
  parameter int DEAD_W = 4
) (
  input  logic           clk_dds,
  input  logic           rst,
  bri_drive_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRIVE, DEAD, DONE} state_t;

  state_t            state, state_nxt;
  logic              start_d;
  logic              start_edge;
  logic [7:0]        base, base_nxt;
  logic [6:0]        n, n_nxt;
  logic              leg, leg_nxt;
  logic [DEAD_W-1:0] dead_cnt, dead_cnt_nxt;
  logic [7:0]        el;
  logic [6:0]        hp;
  logic              want;
  logic              a_nxt, b_nxt, stop_nxt, done_nxt, abort_nxt, busy_nxt;

  // Elapsed quarters are taken modulo 256 so a count wrap mid-pulse is harmless.
  assign start_edge = bus.state_start & ~start_d;
  assign el         = bus.count - base;
  assign hp         = el[7:1];
  assign want       = el[1];

  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    n_nxt        = n;
    leg_nxt      = leg;
    dead_cnt_nxt = dead_cnt;
    a_nxt        = 1'b0;
    b_nxt        = 1'b0;
    stop_nxt     = 1'b0;
    done_nxt     = 1'b0;
    abort_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (start_edge) begin
          base_nxt = bus.count;
          n_nxt    = bus.half_num[6:0];
          leg_nxt  = 1'b0;
          if (bus.half_num[6:0] != 7'd0) begin
            state_nxt = DRIVE;
            a_nxt     = 1'b1;
          end else begin
            state_nxt = DONE;
            stop_nxt  = 1'b1;
            done_nxt  = 1'b1;
          end
        end
      end

      DRIVE: begin
        if (!bus.state_start) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (hp == n) begin
          state_nxt = DONE;
          stop_nxt  = 1'b1;
          done_nxt  = 1'b1;
        end else if (want != leg) begin
          // Both legs stay low for at least this cycle; zero dead time re-enters DRIVE.
          leg_nxt      = want;
          dead_cnt_nxt = bus.dead_cyc;
          if (bus.dead_cyc != '0) state_nxt = DEAD;
        end else begin
          a_nxt = ~leg;
          b_nxt = leg;
        end
      end

      DEAD: begin
        if (!bus.state_start) begin
          state_nxt = IDLE;
          abort_nxt = 1'b1;
        end else if (hp == n) begin
          state_nxt = DONE;
          stop_nxt  = 1'b1;
          done_nxt  = 1'b1;
        end else if (dead_cnt <= DEAD_W'(1)) begin
          state_nxt = DRIVE;
          leg_nxt   = want;
          a_nxt     = ~want;
          b_nxt     = want;
        end else begin
          dead_cnt_nxt = dead_cnt - DEAD_W'(1);
        end
      end

      DONE: begin
        stop_nxt = 1'b1;
        if (!bus.state_start) begin
          state_nxt = IDLE;
          stop_nxt  = 1'b0;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == DRIVE) || (state_nxt == DEAD);
  end

  always_ff @(posedge clk_dds or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      start_d         <= 1'b0;
      base            <= 8'd0;
      n               <= 7'd0;
      leg             <= 1'b0;
      dead_cnt        <= '0;
      bus.bri_a       <= 1'b0;
      bus.bri_b       <= 1'b0;
      bus.timer_stop  <= 1'b0;
      bus.pulse_done  <= 1'b0;
      bus.pulse_abort <= 1'b0;
      bus.busy        <= 1'b0;
      bus.phase_tick  <= 1'b0;
    end else begin
      state           <= state_nxt;
      start_d         <= bus.state_start;
      base            <= base_nxt;
      n               <= n_nxt;
      leg             <= leg_nxt;
      dead_cnt        <= dead_cnt_nxt;
      bus.bri_a       <= a_nxt;
      bus.bri_b       <= b_nxt;
      bus.timer_stop  <= stop_nxt;
      bus.pulse_done  <= done_nxt;
      bus.pulse_abort <= abort_nxt;
      bus.busy        <= busy_nxt;
      bus.phase_tick  <= bus.clk_4f_en & busy_nxt;
    end
  end

endmodule

// File: tb/tb_bri_drive_seq.sv
// Directed bench for bri_drive_seq: normal, wrap, zero-length, abort, no-dead-time
// and async-reset pulses, with a per-cycle check that both legs are never on together.
module tb_bri_drive_seq;
  localparam int DEAD_W = 4;

  logic clk_dds = 1'b0;
  logic rst     = 1'b1;
  int   checks   = 0;
  int   failures = 0;
  int   done_cnt;
  int   low_cnt;

  bri_drive_seq_if #(.DEAD_W(DEAD_W)) bus ();

  bri_drive_seq #(.DEAD_W(DEAD_W)) dut (
    .clk_dds (clk_dds),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 clk_dds = ~clk_dds;

  // Shoot-through guard sampled on the falling edge of every cycle.
  always @(negedge clk_dds) begin
    checks++;
    assert ((bus.bri_a & bus.bri_b) === 1'b0)
      else begin
        failures++;
        $error("[TB] FAIL shoot_through observed=%0b expected=0", bus.bri_a & bus.bri_b);
      end
  end

  task automatic check_output(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
  endtask

  task automatic check_count(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic step();
    @(posedge clk_dds);
    #1;
  endtask

  task automatic apply_stimulus(input logic start, input logic [7:0] cnt);
    bus.state_start = start;
    bus.count       = cnt;
    step();
  endtask

  initial begin
    bus.clk_4f_en   = 1'b0;
    bus.state_start = 1'b0;
    bus.count       = 8'd0;
    bus.half_num    = 8'd0;
    bus.dead_cyc    = '0;
    step();
    step();
    check_output("rst_a",     bus.bri_a,       1'b0);
    check_output("rst_b",     bus.bri_b,       1'b0);
    check_output("rst_stop",  bus.timer_stop,  1'b0);
    check_output("rst_done",  bus.pulse_done,  1'b0);
    check_output("rst_abort", bus.pulse_abort, 1'b0);
    check_output("rst_busy",  bus.busy,        1'b0);
    check_output("rst_tick",  bus.phase_tick,  1'b0);
    rst = 1'b0;

    bus.clk_4f_en = 1'b1;
    apply_stimulus(1'b0, 8'd0);
    check_output("idle_tick_gated", bus.phase_tick, 1'b0);
    bus.clk_4f_en = 1'b0;

    $display("[TB] normal pulse: half_num=4 dead_cyc=2");
    bus.half_num = 8'd4;
    bus.dead_cyc = 4'd2;
    done_cnt = 0;
    for (int j = 0; j <= 33; j++) begin
      bus.clk_4f_en = (j == 5);
      apply_stimulus(1'b1, 8'(j / 4));
      if (bus.pulse_done) done_cnt++;
      case (j)
        0:  begin check_output("norm_a_start", bus.bri_a, 1'b1); check_output("norm_busy_start", bus.busy, 1'b1); end
        5:  check_output("norm_tick_on", bus.phase_tick, 1'b1);
        6:  check_output("norm_tick_off", bus.phase_tick, 1'b0);
        7:  begin check_output("norm_a_j7", bus.bri_a, 1'b1); check_output("norm_b_j7", bus.bri_b, 1'b0); end
        8:  begin check_output("norm_a_dead1", bus.bri_a, 1'b0); check_output("norm_b_dead1", bus.bri_b, 1'b0); end
        9:  begin check_output("norm_b_dead2", bus.bri_b, 1'b0); check_output("norm_busy_dead", bus.busy, 1'b1); end
        10: begin check_output("norm_b_on", bus.bri_b, 1'b1); check_output("norm_a_off", bus.bri_a, 1'b0); end
        15: check_output("norm_b_j15", bus.bri_b, 1'b1);
        17: begin check_output("norm_a_j17", bus.bri_a, 1'b0); check_output("norm_b_j17", bus.bri_b, 1'b0); end
        18: check_output("norm_a_j18", bus.bri_a, 1'b1);
        26: check_output("norm_b_j26", bus.bri_b, 1'b1);
        31: begin check_output("norm_b_j31", bus.bri_b, 1'b1); check_output("norm_done_early", bus.pulse_done, 1'b0); end
        32: begin
          check_output("norm_done", bus.pulse_done, 1'b1);
          check_output("norm_stop", bus.timer_stop, 1'b1);
          check_output("norm_a_end", bus.bri_a, 1'b0);
          check_output("norm_b_end", bus.bri_b, 1'b0);
          check_output("norm_busy_end", bus.busy, 1'b0);
        end
        33: begin check_output("norm_done_once", bus.pulse_done, 1'b0); check_output("norm_stop_hold", bus.timer_stop, 1'b1); end
        default: ;
      endcase
    end
    bus.clk_4f_en = 1'b0;
    check_count("norm_done_count", done_cnt, 1);
    apply_stimulus(1'b1, 8'd9);
    check_output("norm_stop_extra_q", bus.timer_stop, 1'b1);
    check_output("norm_a_extra_q", bus.bri_a, 1'b0);
    apply_stimulus(1'b0, 8'd9);
    check_output("norm_stop_clear", bus.timer_stop, 1'b0);

    $display("[TB] wrap pulse: base=250 half_num=5");
    bus.half_num = 8'd5;
    for (int j = 0; j <= 41; j++) begin
      apply_stimulus(1'b1, 8'(250 + j / 4));
      case (j)
        23: check_output("wrap_a_c255", bus.bri_a, 1'b1);
        27: check_output("wrap_b_c0", bus.bri_b, 1'b1);
        31: check_output("wrap_b_c1", bus.bri_b, 1'b1);
        39: begin check_output("wrap_a_c3", bus.bri_a, 1'b1); check_output("wrap_done_early", bus.pulse_done, 1'b0); end
        40: begin
          check_output("wrap_done_c4", bus.pulse_done, 1'b1);
          check_output("wrap_stop_c4", bus.timer_stop, 1'b1);
          check_output("wrap_a_c4", bus.bri_a, 1'b0);
        end
        41: begin check_output("wrap_done_once", bus.pulse_done, 1'b0); check_output("wrap_stop_hold", bus.timer_stop, 1'b1); end
        default: ;
      endcase
    end
    apply_stimulus(1'b0, 8'd4);
    check_output("wrap_stop_clear", bus.timer_stop, 1'b0);

    $display("[TB] zero-length pulse");
    bus.half_num = 8'd0;
    apply_stimulus(1'b1, 8'd17);
    check_output("zero_done", bus.pulse_done, 1'b1);
    check_output("zero_stop", bus.timer_stop, 1'b1);
    check_output("zero_a", bus.bri_a, 1'b0);
    check_output("zero_b", bus.bri_b, 1'b0);
    check_output("zero_busy", bus.busy, 1'b0);
    apply_stimulus(1'b1, 8'd17);
    check_output("zero_done_once", bus.pulse_done, 1'b0);
    check_output("zero_stop_hold", bus.timer_stop, 1'b1);
    check_output("zero_a_hold", bus.bri_a, 1'b0);
    apply_stimulus(1'b0, 8'd17);
    check_output("zero_stop_clear", bus.timer_stop, 1'b0);

    $display("[TB] abort during dead time of third half-period");
    bus.half_num = 8'd4;
    bus.dead_cyc = 4'd2;
    for (int j = 0; j <= 16; j++) apply_stimulus(1'b1, 8'(j / 4));
    check_output("abort_pre_a", bus.bri_a, 1'b0);
    check_output("abort_pre_b", bus.bri_b, 1'b0);
    check_output("abort_pre_busy", bus.busy, 1'b1);
    apply_stimulus(1'b0, 8'd4);
    check_output("abort_strobe", bus.pulse_abort, 1'b1);
    check_output("abort_a", bus.bri_a, 1'b0);
    check_output("abort_b", bus.bri_b, 1'b0);
    check_output("abort_stop", bus.timer_stop, 1'b0);
    check_output("abort_busy", bus.busy, 1'b0);
    check_output("abort_done", bus.pulse_done, 1'b0);
    apply_stimulus(1'b0, 8'd4);
    check_output("abort_once", bus.pulse_abort, 1'b0);

    $display("[TB] zero dead time: half_num=3");
    bus.half_num = 8'd3;
    bus.dead_cyc = 4'd0;
    low_cnt = 0;
    for (int j = 0; j <= 24; j++) begin
      apply_stimulus(1'b1, 8'(j / 4));
      if (j <= 23 && !bus.bri_a && !bus.bri_b) low_cnt++;
      case (j)
        7:  check_output("nodead_a_j7", bus.bri_a, 1'b1);
        8:  begin check_output("nodead_a_j8", bus.bri_a, 1'b0); check_output("nodead_b_j8", bus.bri_b, 1'b0); end
        9:  check_output("nodead_b_j9", bus.bri_b, 1'b1);
        16: check_output("nodead_b_j16", bus.bri_b, 1'b0);
        17: check_output("nodead_a_j17", bus.bri_a, 1'b1);
        24: check_output("nodead_done", bus.pulse_done, 1'b1);
        default: ;
      endcase
    end
    check_count("nodead_low_cycles", low_cnt, 2);
    apply_stimulus(1'b0, 8'd6);
    check_output("nodead_stop_clear", bus.timer_stop, 1'b0);

    $display("[TB] async reset mid-drive, then fresh pulse");
    bus.half_num = 8'd4;
    bus.dead_cyc = 4'd2;
    for (int j = 0; j <= 5; j++) apply_stimulus(1'b1, 8'(100 + j / 4));
    check_output("rstmid_a_before", bus.bri_a, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_output("rstmid_a_async", bus.bri_a, 1'b0);
    check_output("rstmid_b_async", bus.bri_b, 1'b0);
    check_output("rstmid_busy_async", bus.busy, 1'b0);
    bus.state_start = 1'b0;
    #2;
    rst = 1'b0;
    apply_stimulus(1'b1, 8'd102);
    check_output("rstmid_restart_a", bus.bri_a, 1'b1);
    apply_stimulus(1'b1, 8'd102);
    check_output("rstmid_base_relatched", bus.bri_a, 1'b1);
    apply_stimulus(1'b1, 8'd104);
    check_output("rstmid_leg_change_a", bus.bri_a, 1'b0);
    check_output("rstmid_leg_change_b", bus.bri_b, 1'b0);
    check_output("rstmid_leg_change_busy", bus.busy, 1'b1);
    apply_stimulus(1'b0, 8'd104);
    check_output("rstmid_abort", bus.pulse_abort, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bri_drive_seq.md
# bri_drive_seq

H-bridge transmit-pulse sequencer that consumes the 8-bit quarter-period count from the bridge timer and produces dead-time-protected gate drives for the two diagonal legs of the NMR transmit bridge. It measures the programmed pulse length in RF half-periods. At the end of the pulse it asserts `timer_stop` back to the timer so the count freezes. It sits directly downstream of the bridge timer, in the `clk_dds` domain.

## Interface
- `DEAD_W`, default 4: width of the dead-time field.
- `clk_dds`  in  1  DDS system clock; all logic is rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `clk_4f_en`  in  1  one-cycle enable at 4× Larmor frequency; used only for the `phase_tick` output.
- `state_start`  in  1  level; high for the duration of the transmit state.
- `count`  in  8  quarter-period count from the bridge timer; increments by at most 1 per cycle and wraps 255→0.
- `half_num`  in  8  pulse length in RF half-periods; bit 7 is ignored, so the usable range is 0..127.
- `dead_cyc`  in  DEAD_W  dead time in `clk_dds` cycles; 0 means no dead time.
- `bri_a`  out  1  gate drive for leg pair A (positive half-periods).
- `bri_b`  out  1  gate drive for leg pair B (negative half-periods).
- `timer_stop`  out  1  freeze request to the bridge timer.
- `pulse_done`  out  1  one-cycle strobe when a pulse completes normally.
- `pulse_abort`  out  1  one-cycle strobe when `state_start` falls mid-pulse.
- `busy`  out  1  high in DRIVE or DEAD.
- `phase_tick`  out  1  registered copy of `clk_4f_en`, gated by `busy`.

## Operation
- Start detection:
  - `state_start` is registered into `start_d`.
  - A start edge is `state_start & ~start_d`.
  - On a start edge, latch `base = count` and `n = half_num[6:0]`.
- Elapsed quarters `el = count - base`, 8-bit modulo, so wrap of `count` is harmless.
  - Half-period index: `hp = el[7:1]`.
  - Desired leg: `el[1] == 0` selects A, `el[1] == 1` selects B.
- States:
  - IDLE:
    - All outputs low.
    - Start edge with n≠0 → DRIVE, leg A.
    - Start edge with n=0 → DONE; `pulse_done` pulses and `timer_stop` is set.
  - DRIVE:
    - The current leg's output is high.
    - `hp == n` → DONE: both legs low, `timer_stop` set, `pulse_done` pulses. This check has priority over the leg change.
    - Desired leg ≠ current leg → both legs low and the dead counter is loaded with `dead_cyc`.
      - If `dead_cyc` = 0, drive the new leg on the next cycle directly, staying in DRIVE.
      - Otherwise → DEAD.
  - DEAD:
    - Both legs low; the counter decrements each cycle.
    - At 1 → DRIVE with the desired leg as evaluated at that cycle.
    - `hp == n` during DEAD → DONE.
  - DONE:
    - `timer_stop` held high, legs low.
    - `state_start` low → IDLE; `timer_stop` clears.
- Abort: `state_start` low while in DRIVE or DEAD → IDLE.
  - Legs go low on the next edge and `pulse_abort` pulses once.
  - `timer_stop` is not asserted on abort.
- Invariant: `bri_a & bri_b` is never 1 on any cycle, including across reset and abort.
- `half_num` and `dead_cyc` changes after the start edge have no effect on the current pulse, except that `dead_cyc` is sampled at each leg change.

## Timing
- Reset values: all outputs 0, state IDLE, `start_d` 0, `base` 0, `n` 0.
  - Reset asserted mid-pulse drives both legs low asynchronously.
- Start edge at cycle t → `bri_a` high at t+1.
- Leg change: `el[1]` changes at cycle t → both legs low at t+1.
  - New leg high at t+1+`dead_cyc`; with `dead_cyc` = 0, at t+2.
- End of pulse: `hp` reaches n at cycle t → legs low, `timer_stop` = 1 and `pulse_done` = 1 at t+1.
  - The timer may advance `count` by one more quarter before freezing; that is tolerated because DONE ignores `count`.
- A start edge while in DONE is impossible, since it requires `state_start` to have fallen first.
- Registered outputs only; no combinational path from inputs to outputs.

## Test plan
- Normal pulse:
  - Stimulus: `half_num`=4, `dead_cyc`=2, `count` from 0 advancing every 4 clocks.
  - Expect A, B, A, B windows, each the half-period minus 2 dead cycles after every edge.
  - `pulse_done` fires once when `count`=8; `timer_stop` stays high until `state_start` falls.
- Wrap:
  - Stimulus: `base`=250, `half_num`=5.
  - Expect the pulse to end at `count`=4 (el=10) with correct A/B alternation across 255→0.
- Zero length:
  - Stimulus: `half_num`=0.
  - Expect `bri_a`/`bri_b` to stay 0, `pulse_done` and `timer_stop` at t+1.
- Abort:
  - Stimulus: drop `state_start` during DEAD in the 3rd half-period.
  - Expect legs low next cycle, `pulse_abort`=1 for one cycle, `timer_stop`=0, state IDLE.
- No dead time:
  - Stimulus: `dead_cyc`=0.
  - Expect exactly one all-low cycle at each leg change.
  - Assert `bri_a & bri_b` == 0 on every cycle across all tests.
- Reset:
  - Stimulus: assert `rst` asynchronously mid-DRIVE.
  - Expect outputs 0 immediately.
  - After release, the next start edge begins a fresh pulse with `base` re-latched.
